// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider,
// valid/ready handshake on request and result, flushable.
module muldiv_unit #(
    parameter int DWIDTH   = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [DWIDTH-1:0] rs1_i,
    input  logic [DWIDTH-1:0] rs2_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              busy_o
);

    localparam int CW = $clog2(DWIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [2:0]          op;
    logic [DWIDTH-1:0]   a_mag, b_mag, a_raw;
    logic                neg_res, div_zero, div_ovf;
    logic [2*DWIDTH-1:0] acc, acc_nxt, prod_raw, prod_s;
    logic [DWIDTH:0]     rem, rem_nxt, shifted, mul_sum;
    logic [DWIDTH+1:0]   trial;
    logic [DWIDTH-1:0]   quo, quo_nxt, q_s, r_s, mul_res, div_res, calc_res;

    logic                accept, cnt_last, is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic                in_div0, in_ovf, in_fast, neg_in;
    logic [DWIDTH-1:0]   a_mag_in, b_mag_in;

    assign ready_o  = (state == IDLE);
    assign valid_o  = (state == DONE);
    assign busy_o   = (state != IDLE);
    assign accept   = start_i && ready_o && !flush_i;
    assign cnt_last = (cnt == CW'(1));

    // Request decode: operand signedness, magnitudes and the single-cycle special cases.
    assign is_div   = funct3_i[2];
    assign a_sgn    = is_div ? !funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
    assign b_sgn    = is_div ? !funct3_i[0] : (funct3_i[1:0] == 2'b01);
    assign a_neg    = a_sgn && rs1_i[DWIDTH-1];
    assign b_neg    = b_sgn && rs2_i[DWIDTH-1];
    assign a_mag_in = a_neg ? -rs1_i : rs1_i;
    assign b_mag_in = b_neg ? -rs2_i : rs2_i;
    assign in_div0  = is_div && (rs2_i == '0);
    assign in_ovf   = is_div && !funct3_i[0] && (rs1_i == {1'b1, {(DWIDTH-1){1'b0}}}) && (rs2_i == '1);
    assign in_fast  = in_div0 || in_ovf || (!is_div && FAST_MUL);
    assign neg_in   = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

    // One shift-add multiplier step and one restoring divider step per CALC cycle.
    always_comb begin
        mul_sum = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        acc_nxt = {mul_sum, acc[DWIDTH-1:1]};
        shifted = {rem[DWIDTH-1:0], quo[DWIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, b_mag};
        rem_nxt = shifted;
        quo_nxt = {quo[DWIDTH-2:0], 1'b0};
        if (!trial[DWIDTH+1]) begin
            rem_nxt = trial[DWIDTH:0];
            quo_nxt = {quo[DWIDTH-2:0], 1'b1};
        end
    end

    generate
        if (FAST_MUL) begin : g_fast
            assign prod_raw = {{DWIDTH{1'b0}}, a_mag} * {{DWIDTH{1'b0}}, b_mag};
        end else begin : g_iter
            assign prod_raw = acc_nxt;
        end
    endgenerate

    // Sign correction and result selection, evaluated on the final CALC cycle.
    always_comb begin
        prod_s  = neg_res ? -prod_raw : prod_raw;
        mul_res = (op[1:0] == 2'b00) ? prod_s[DWIDTH-1:0] : prod_s[2*DWIDTH-1:DWIDTH];
        q_s     = neg_res ? -quo_nxt : quo_nxt;
        r_s     = neg_res ? -rem_nxt[DWIDTH-1:0] : rem_nxt[DWIDTH-1:0];
        div_res = op[1] ? r_s : q_s;
        if (div_zero)
            calc_res = op[1] ? a_raw : '1;
        else if (div_ovf)
            calc_res = op[1] ? '0 : a_raw;
        else
            calc_res = op[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Flush overrides every transition and always lands in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = CALC;
            CALC:    if (cnt_last) state_nxt = DONE;
            DONE:    if (ready_i)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
        if (flush_i)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            op       <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            a_raw    <= '0;
            neg_res  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            res_o    <= '0;
        end else if (accept) begin
            cnt      <= in_fast ? CW'(1) : CW'(DWIDTH);
            op       <= funct3_i;
            a_mag    <= a_mag_in;
            b_mag    <= b_mag_in;
            a_raw    <= rs1_i;
            neg_res  <= neg_in;
            div_zero <= in_div0;
            div_ovf  <= in_ovf;
            acc      <= {{DWIDTH{1'b0}}, b_mag_in};
            rem      <= '0;
            quo      <= a_mag_in;
        end else if (state == CALC && !flush_i) begin
            acc <= acc_nxt;
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (cnt_last)
                res_o <= calc_res;
            else
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit (iterative and fast-multiply builds)
// using an expected-result queue and cycle-accurate latency checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n, start_i, flush_i, ready_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        ready_o, valid_o, busy_o;
    logic [31:0] res_o;
    logic        start_f, ready_f, ready_o_f, valid_o_f, busy_o_f;
    logic [31:0] res_o_f;

    int          total = 0;
    int          bad   = 0;
    int          cyc;
    int          seen;
    logic [31:0] got;
    logic [31:0] sb_q[$];

    muldiv_unit #(.DWIDTH(32), .FAST_MUL(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .ready_o(ready_o),
        .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .busy_o(busy_o)
    );

    muldiv_unit #(.DWIDTH(32), .FAST_MUL(1'b1)) dut_fast (
        .clk(clk), .reset_n(reset_n), .start_i(start_f), .ready_o(ready_o_f),
        .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
        .valid_o(valid_o_f), .ready_i(ready_f), .res_o(res_o_f), .busy_o(busy_o_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model built from 64-bit arithmetic on extended operands.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb, sr;
        logic [31:0]        r;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin sr = sa / sb; r = sr; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin sr = sa % sb; r = sr; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 2;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
        start_i  = 1'b1;
        funct3_i = f;
        rs1_i    = a;
        rs2_i    = b;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        rs1_i    = $urandom;
        rs2_i    = $urandom;
        funct3_i = 3'($urandom);
    endtask

    task automatic waitValid(input string tag, input int exp_cyc);
        int c;
        c = 1;
        while (!valid_o && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check({tag, "_latency"}, 32'(c), 32'(exp_cyc));
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] r;
        @(negedge clk);
        r       = res_o;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check({tag, "_res"}, r, sb_q.pop_front());
    endtask

    task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        sb_q.push_back(exp);
        applyStimulus(tag, f, a, b);
        waitValid(tag, exp_cyc);
        checkOutput(tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        start_i  = 1'b0;
        start_f  = 1'b0;
        flush_i  = 1'b0;
        ready_i  = 1'b0;
        ready_f  = 1'b0;
        funct3_i = 3'd0;
        rs1_i    = '0;
        rs2_i    = '0;
        #12;
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_busy",  {31'b0, busy_o},  32'd0);
        check("rst_res",   res_o,            32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        runOp("mul",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        runOp("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        runOp("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        runOp("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        runOp("div",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        runOp("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        runOp("divu",    3'd5, 32'd100,       32'd7,         32'd14,        33);
        runOp("remu",    3'd7, 32'd100,       32'd7,         32'd2,         33);
        runOp("div0",    3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        runOp("rem0",    3'd6, 32'd5,         32'd0,         32'd5,         2);
        runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'(i);
            a = $urandom;
            b = (i == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            runOp($sformatf("rnd%0d", i), f, a, b, model(f, a, b), model_lat(f, a, b));
        end

        // Fast-multiply build: product available after a single CALC cycle.
        @(negedge clk);
        start_f  = 1'b1;
        funct3_i = 3'd0;
        rs1_i    = 32'd7;
        rs2_i    = 32'hFFFF_FFFD;
        sb_q.push_back(32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        start_f = 1'b0;
        rs1_i   = $urandom;
        cyc     = 1;
        while (!valid_o_f && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("fast_latency", 32'(cyc), 32'd2);
        @(negedge clk);
        got     = res_o_f;
        ready_f = 1'b1;
        @(posedge clk);
        #1;
        ready_f = 1'b0;
        check("fast_res", got, sb_q.pop_front());

        // Backpressure, then a start presented during the handoff cycle.
        sb_q.push_back(32'd14);
        applyStimulus("bp", 3'd5, 32'd100, 32'd7);
        waitValid("bp", 33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", {31'b0, valid_o}, 32'd1);
            check("bp_res_hold",   res_o,            32'd14);
            check("bp_ready_low",  {31'b0, ready_o}, 32'd0);
        end
        @(negedge clk);
        got      = res_o;
        ready_i  = 1'b1;
        start_i  = 1'b1;
        funct3_i = 3'd7;
        rs1_i    = 32'd100;
        rs2_i    = 32'd7;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check("bp_res", got, sb_q.pop_front());
        check("handoff_no_accept", {31'b0, busy_o},  32'd0);
        check("handoff_ready",     {31'b0, ready_o}, 32'd1);
        sb_q.push_back(32'd2);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("b2b_accept", {31'b0, busy_o}, 32'd1);
        waitValid("b2b", 33);
        checkOutput("b2b");

        // Flush in the middle of CALC.
        applyStimulus("flush", 3'd5, 32'd100, 32'd7);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_ready", {31'b0, ready_o}, 32'd1);
        check("flush_busy",  {31'b0, busy_o},  32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        // Flush together with start: no accept.
        @(negedge clk);
        flush_i  = 1'b1;
        start_i  = 1'b1;
        funct3_i = 3'd5;
        rs1_i    = 32'd9;
        rs2_i    = 32'd3;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        check("flush_start_busy", {31'b0, busy_o}, 32'd0);

        // Flush together with ready in DONE: result dropped, unit returns to IDLE.
        applyStimulus("flush_done", 3'd4, 32'd5, 32'd0);
        waitValid("flush_done", 2);
        @(negedge clk);
        flush_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        check("flush_done_valid", {31'b0, valid_o}, 32'd0);
        check("flush_done_ready", {31'b0, ready_o}, 32'd1);

        // Asynchronous reset in the middle of CALC.
        applyStimulus("arst", 3'd5, 32'd100, 32'd7);
        cyc = 1;
        while (cyc < 5) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ready", {31'b0, ready_o}, 32'd1);
        check("arst_busy",  {31'b0, busy_o},  32'd0);
        check("arst_valid", {31'b0, valid_o}, 32'd0);
        check("arst_res",   res_o,            32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        runOp("post_rst", 3'd5, 32'd9, 32'd3, 32'd3, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
